// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, default offsets and byte-lane merge for the machine timer slave
package timer_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MTIME,
        SEL_MTIMECMP,
        SEL_MSIP
    } sel_e;

    localparam logic [15:0] DEFAULT_MTIMECMP_OFFSET = 16'h4000;
    localparam logic [15:0] DEFAULT_MTIME_OFFSET    = 16'hBFF8;
    localparam logic [15:0] MSIP_OFFSET             = 16'h0000;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_timer_slave_if.sv
// rtl/axi_lite_timer_slave_if.sv - AXI4-Lite bus bundle between the core MMIO master and the timer slave
interface axi_lite_timer_slave_if #(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - prescaled mtime counter, mtimecmp register and registered timer interrupt
module timer_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_we,
    input  logic        mtimecmp_we,
    input  logic [63:0] wdata,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        time_int
);
    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic [63:0]   mtime_next;
    logic [63:0]   mtimecmp_next;

    assign tick = (prescaler == LAST);

    // A bus write to mtime overrides a coinciding tick; the prescaler keeps its phase.
    always_comb begin
        mtime_next = tick ? mtime + 64'd1 : mtime;
        if (mtime_we) begin
            mtime_next = wdata;
        end
        mtimecmp_next = mtimecmp_we ? wdata : mtimecmp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            time_int  <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            time_int  <= (mtime_next >= mtimecmp_next);
        end
    end
endmodule

// File: rtl/axi_lite_timer_slave.sv
// rtl/axi_lite_timer_slave.sv - AXI4-Lite slave exposing mtime/mtimecmp and time_int; TIMER_MSIP_EN adds msip/soft_int
module axi_lite_timer_slave
    import timer_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 64,
    parameter int          DATA_WIDTH      = 64,
    parameter logic [15:0] MTIMECMP_OFFSET = DEFAULT_MTIMECMP_OFFSET,
    parameter logic [15:0] MTIME_OFFSET    = DEFAULT_MTIME_OFFSET,
    parameter int          TICK_DIV        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_timer_slave_if.slave  s,
`ifdef TIMER_MSIP_EN
    output logic                   soft_int,
`endif
    output logic                   time_int
);
    wstate_e               wstate, wstate_next;
    rstate_e               rstate, rstate_next;
    logic [12:0]           aw_off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            wstrb_q;
    resp_e                 bresp_q, rresp_q;
    logic [63:0]           rdata_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [12:0]           wr_off;
    logic [63:0]           wr_data, wr_old, wr_merged, rd_val;
    logic [7:0]            wr_strb;
    sel_e                  wr_sel, rd_sel;
    logic [63:0]           mtime, mtimecmp, msip_word;
    logic                  unused_addr_bits;

    function automatic sel_e decode(input logic [12:0] off);
        if (off == MTIME_OFFSET[15:3])    return SEL_MTIME;
        if (off == MTIMECMP_OFFSET[15:3]) return SEL_MTIMECMP;
`ifdef TIMER_MSIP_EN
        if (off == MSIP_OFFSET[15:3])     return SEL_MSIP;
`endif
        return SEL_NONE;
    endfunction

    assign unused_addr_bits = ^{s.awaddr[ADDR_WIDTH-1:16], s.awaddr[2:0],
                                s.araddr[ADDR_WIDTH-1:16], s.araddr[2:0]};

    assign s.awready = (wstate == W_IDLE) || (wstate == W_HAVE_W);
    assign s.wready  = (wstate == W_IDLE) || (wstate == W_HAVE_AW);
    assign s.bvalid  = (wstate == W_RESP);
    assign s.bresp   = bresp_q;
    assign s.arready = (rstate == R_IDLE);
    assign s.rvalid  = (rstate == R_DATA);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid && s.wready;
    assign ar_hs = s.arvalid && s.arready;

    // Whichever half arrives second is taken straight off the bus so the commit needs no extra cycle.
    assign wr_off  = (wstate == W_HAVE_AW) ? aw_off_q : s.awaddr[15:3];
    assign wr_data = (wstate == W_HAVE_W) ? wdata_q : s.wdata;
    assign wr_strb = (wstate == W_HAVE_W) ? wstrb_q : s.wstrb;
    assign wr_sel  = decode(wr_off);
    assign rd_sel  = decode(s.araddr[15:3]);

    always_comb begin
        wr_old = '0;
        rd_val = '0;
        case (wr_sel)
            SEL_MTIME:    wr_old = mtime;
            SEL_MTIMECMP: wr_old = mtimecmp;
            SEL_MSIP:     wr_old = msip_word;
            default:      wr_old = '0;
        endcase
        case (rd_sel)
            SEL_MTIME:    rd_val = mtime;
            SEL_MTIMECMP: rd_val = mtimecmp;
            SEL_MSIP:     rd_val = msip_word;
            default:      rd_val = '0;
        endcase
    end

    assign wr_merged = strb_merge(wr_old, wr_data, wr_strb);

    always_comb begin
        wstate_next = wstate;
        commit      = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    wstate_next = W_RESP;
                end else if (aw_hs) begin
                    wstate_next = W_HAVE_AW;
                end else if (w_hs) begin
                    wstate_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                commit      = 1'b1;
                wstate_next = W_RESP;
            end
            W_HAVE_W: if (aw_hs) begin
                commit      = 1'b1;
                wstate_next = W_RESP;
            end
            W_RESP: if (s.bready) wstate_next = W_IDLE;
            default: wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_next = R_DATA;
            R_DATA:  if (s.rready) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_next;
            rstate <= rstate_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_off_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            if (aw_hs) aw_off_q <= s.awaddr[15:3];
            if (w_hs) begin
                wdata_q <= s.wdata;
                wstrb_q <= s.wstrb;
            end
            if (commit) bresp_q <= (wr_sel == SEL_NONE) ? SLVERR : OKAY;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= (rd_sel == SEL_NONE) ? SLVERR : OKAY;
            end
        end
    end

`ifdef TIMER_MSIP_EN
    logic msip_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
        end else if (commit && wr_sel == SEL_MSIP) begin
            msip_q <= wr_merged[0];
        end
    end
    assign msip_word = {63'b0, msip_q};
    assign soft_int  = msip_q;
`else
    assign msip_word = '0;
`endif

    timer_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .mtime_we    (commit && wr_sel == SEL_MTIME),
        .mtimecmp_we (commit && wr_sel == SEL_MTIMECMP),
        .wdata       (wr_merged),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .time_int    (time_int)
    );
endmodule

// File: doc/axi_lite_timer_slave.md
Name: axi_lite_timer_slave

Overview:
- AXI4-Lite responder (slave end) hosting the machine timer registers mtime and mtimecmp on the MMIO bus.
- Answers the core's MMIO master port.
- Generates the level timer interrupt `time_int` consumed by the core.
- Read and write channels are handled by independent FSMs.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI data width; fixed at 64, one register per beat.
- MTIMECMP_OFFSET, 16'h4000, offset of mtimecmp (compared against addr[15:0]).
- MTIME_OFFSET, 16'hBFF8, offset of mtime.
- TICK_DIV, 1, clk cycles per mtime increment; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1 ; s_awready  out  1 : write-address handshake.
- s_wdata  in  64 ; s_wstrb  in  8 ; s_wvalid  in  1 ; s_wready  out  1 : write-data channel.
- s_bresp  out  2 ; s_bvalid  out  1 ; s_bready  in  1 : write response.
- s_araddr  in  ADDR_WIDTH ; s_arvalid  in  1 ; s_arready  out  1 : read-address channel.
- s_rdata  out  64 ; s_rresp  out  2 ; s_rvalid  out  1 ; s_rready  in  1 : read data.
- time_int  out  1  registered, high while mtime >= mtimecmp (unsigned).

Behaviour:
- Reset values (clk with rst=1):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0.
  - time_int=0; all valid outputs 0; s_bresp=s_rresp=0; s_rdata=0.
  - Both FSMs return to idle; any transaction in flight is dropped with no response.
- Decode on addr[15:3]; addr[2:0] are ignored. An unmapped offset gives SLVERR (2'b10): writes to it are discarded and reads return 0. A mapped offset gives OKAY (2'b00).
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - s_awready=1 in W_IDLE and W_HAVE_W; s_wready=1 in W_IDLE and W_HAVE_AW.
  - AW and W may arrive in the same cycle or in either order. Each is latched on its handshake.
  - The cycle in which both are held, the register write commits (byte-lane merge by s_wstrb) and the FSM goes to W_RESP.
  - s_bvalid=1 in W_RESP, held stable until s_bready; then back to W_IDLE.
  - Exactly one outstanding write; no AW or W is accepted in W_RESP.
- Read FSM states: R_IDLE, R_DATA.
  - s_arready=1 only in R_IDLE. On the handshake, the register value present in that cycle (pre-increment) is captured into s_rdata, and s_rvalid rises next cycle.
  - rdata/rresp are held stable until s_rready; then back to R_IDLE.
  - Minimum read latency: 1 cycle after AR handshake.
- Prescaler counts 0..TICK_DIV-1. On wrap, mtime += 1 with 64-bit modulo wrap (FFFF..FF -> 0).
- A write commit to mtime in the same cycle as an increment: the written value wins and the increment is lost. The prescaler is unaffected.
- time_int is registered from the next-state mtime/mtimecmp, so it reflects a write one cycle after commit. It stays high until mtimecmp is rewritten above mtime or mtime wraps.
- Simultaneous read and write of the same register: the read returns the old value.

Optional Feature:
- TIMER_MSIP_EN defined:
  - Adds msip register at offset 16'h0000. Only bit 0 is writable, upper bits read 0, reset 0.
  - Adds output port soft_int (1 bit) = msip[0].
- Undefined: offset 0 is unmapped (SLVERR), and the soft_int port is absent.

Decomposition:
- Shared package timer_pkg: resp_e (OKAY=2'b00, SLVERR=2'b10), wstate_e, rstate_e, default offset constants, and function strb_merge(old,new,strb).
- One natural sub-module, timer_counter: prescaler, mtime, write override, and comparator producing time_int. Instantiated once.

Test Plan:
- Reset then idle 10 cycles, TICK_DIV=1 -> read MTIME_OFFSET returns 10 ±1 per capture rule, rresp=0, time_int=0.
- Write mtimecmp=20 with AW one cycle before W -> bvalid next cycle after W, bresp=0; time_int rises the cycle after mtime reaches 20.
- Write mtime=FFFF_FFFF_FFFF_FFFE with wstrb=8'hFF -> after 2 ticks mtime reads 0; with mtimecmp=5, time_int drops at wrap.
- Write 64'h1122_3344_5566_7788 to mtimecmp with wstrb=8'h0F -> read returns FFFF_FFFF_5566_7788.
- Read addr offset 16'h1000 -> rresp=2'b10, rdata=0; hold rready=0 5 cycles -> rvalid/rdata stable, arready=0.
- Assert rst while in W_RESP -> bvalid=0 next cycle, mtimecmp=all-ones, FSM accepts new AW immediately.
